// File: rtl/hls_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module : hls_chk_pkg
// Purpose: Shared types for the HLS latency/handshake checker.
//          - state_e : checker FSM encoding (IDLE, WAIT)
//          - err_e   : bit positions inside the packed error vector
// Rev    : 1.0  initial release
// ============================================================================
package hls_chk_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ERR_LAT   = 2'd0,
    ERR_DATA  = 2'd1,
    ERR_TMO   = 2'd2,
    ERR_PROTO = 2'd3
  } err_e;

  localparam int unsigned NUM_ERR = 4;

endpackage : hls_chk_pkg
`default_nettype wire

// File: rtl/hls_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : hls_sat_counter
// Purpose: CNT_W-bit up counter that sticks at all-ones.
// Ports  : Clk   in  clock, rising edge
//          Rst   in  asynchronous active-low reset
//          clr   in  synchronous clear, dominates inc
//          inc   in  count enable
//          count out current count value
// Rev    : 1.0  initial release
// ============================================================================
module hls_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : hls_sat_counter
`default_nettype wire

// File: rtl/hls_lat_checker.sv
`default_nettype none
// ============================================================================
// Module : hls_lat_checker
// Purpose: Watches a Start/Done handshake, measures latency against
//          [MIN_LAT, MAX_LAT], compares NUM_OUT result channels with a
//          reference on Done, and flags timeouts and protocol violations.
// Ports  : Clk, Rst (async active-low), clr (sync counter/sticky clear)
//          Start, Done            DUT handshake strobes
//          chk_en, dut_out, ref_out  per-channel compare inputs (Done cycle)
//          busy                   transaction outstanding
//          lat_err, data_err, timeout_err, proto_err  one-cycle pulses
//          err_sticky             latched on any error
//          txn_count, err_count   saturating counters
//          last_latency           latency of last completed transaction
// Rev    : 1.0  initial release
// ============================================================================
module hls_lat_checker
  import hls_chk_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NUM_OUT   = 2,
  parameter int unsigned MIN_LAT   = 5,
  parameter int unsigned MAX_LAT   = 5,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         clr,
  input  logic                         Start,
  input  logic                         Done,
  input  logic [NUM_OUT-1:0]           chk_en,
  input  logic [NUM_OUT*DATAWIDTH-1:0] dut_out,
  input  logic [NUM_OUT*DATAWIDTH-1:0] ref_out,
  output logic                         busy,
  output logic                         lat_err,
  output logic [NUM_OUT-1:0]           data_err,
  output logic                         timeout_err,
  output logic                         proto_err,
  output logic                         err_sticky,
  output logic [CNT_W-1:0]             txn_count,
  output logic [CNT_W-1:0]             err_count,
  output logic [CNT_W-1:0]             last_latency
);

  // Cycle counter only needs to reach TIMEOUT.
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_LAT);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_LAT);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]     last_latency_q, last_latency_d;
  logic                 lat_err_q, lat_err_d;
  logic [NUM_OUT-1:0]   data_err_q, data_err_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 proto_err_q, proto_err_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [NUM_OUT-1:0]   chan_mis;
  logic                 txn_inc;
  logic [NUM_ERR-1:0]   err_vec;
  logic                 any_err;

  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      chan_mis[i] = chk_en[i] &&
                    (dut_out[i*DATAWIDTH +: DATAWIDTH] != ref_out[i*DATAWIDTH +: DATAWIDTH]);
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_latency_d = last_latency_q;
    lat_err_d      = 1'b0;
    data_err_d     = '0;
    timeout_err_d  = 1'b0;
    proto_err_d    = 1'b0;
    txn_inc        = 1'b0;

    case (state_q)
      IDLE: begin
        // Done with nothing outstanding is a violation, but a coincident
        // Start still opens a new transaction.
        if (Done) proto_err_d = 1'b1;
        if (Start) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        // A second Start is flagged and otherwise ignored.
        if (Start) proto_err_d = 1'b1;
        if (Done) begin
          // Done takes priority over the timeout check, even at cnt==TIMEOUT.
          last_latency_d = CNT_W'(cnt_q);
          lat_err_d      = (cnt_q < MIN_C) || (cnt_q > MAX_C);
          data_err_d     = chan_mis;
          txn_inc        = 1'b1;
          state_d        = IDLE;
        end else if (cnt_q == TMO_C) begin
          last_latency_d = CNT_W'(TIMEOUT);
          timeout_err_d  = 1'b1;
          txn_inc        = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_vec            = '0;
    err_vec[ERR_LAT]   = lat_err_d;
    err_vec[ERR_DATA]  = |data_err_d;
    err_vec[ERR_TMO]   = timeout_err_d;
    err_vec[ERR_PROTO] = proto_err_d;
    any_err            = |err_vec;
    // clr wins over a coincident error for the sticky flag.
    err_sticky_d       = clr ? 1'b0 : (err_sticky_q | any_err);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_latency_q <= '0;
      lat_err_q      <= 1'b0;
      data_err_q     <= '0;
      timeout_err_q  <= 1'b0;
      proto_err_q    <= 1'b0;
      err_sticky_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_latency_q <= last_latency_d;
      lat_err_q      <= lat_err_d;
      data_err_q     <= data_err_d;
      timeout_err_q  <= timeout_err_d;
      proto_err_q    <= proto_err_d;
      err_sticky_q   <= err_sticky_d;
    end
  end

  hls_sat_counter #(.CNT_W(CNT_W)) u_txn_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .clr   (clr),
    .inc   (txn_inc),
    .count (txn_count)
  );

  hls_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .clr   (clr),
    .inc   (any_err),
    .count (err_count)
  );

  assign busy         = (state_q == WAIT);
  assign lat_err      = lat_err_q;
  assign data_err     = data_err_q;
  assign timeout_err  = timeout_err_q;
  assign proto_err    = proto_err_q;
  assign err_sticky   = err_sticky_q;
  assign last_latency = last_latency_q;

endmodule : hls_lat_checker
`default_nettype wire
